// File: rtl/apb5_pkg.sv
// Shared types for the APB5 requester: FSM state encoding and PPROT bit positions.
package apb5_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned PPROT_PRIV  = 0;
  localparam int unsigned PPROT_NSEC  = 1;
  localparam int unsigned PPROT_INSTR = 2;

endpackage

// File: rtl/apb5_wakeup_ctrl.sv
// Holds pwakeup high while a transfer is requested or in flight; drops it after WAKEUP_HOLD
// consecutive quiet idle cycles. Registered output, one cycle after cmd_valid is seen in IDLE.
module apb5_wakeup_ctrl #(
  parameter int unsigned WAKEUP_HOLD = 2
) (
  input  logic pclk,
  input  logic preset,
  input  logic idle_i,
  input  logic cmd_valid_i,
  output logic pwakeup_o
);

  localparam int unsigned CW = (WAKEUP_HOLD > 1) ? $clog2(WAKEUP_HOLD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wake_q, wake_d;

  always_comb begin
    cnt_d  = cnt_q;
    wake_d = wake_q;
    if (!idle_i || cmd_valid_i) begin
      wake_d = 1'b1;
      cnt_d  = '0;
    end else if (wake_q) begin
      // cnt_q counts quiet idle cycles already elapsed; this one is the last allowed
      if (cnt_q == CW'(WAKEUP_HOLD - 1)) begin
        wake_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q  <= '0;
      wake_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wake_q <= wake_d;
    end
  end

  assign pwakeup_o = wake_q;

endmodule

// File: rtl/apb5_requester.sv
// APB5 requester: cmd stream -> SETUP/ACCESS transfer -> single-entry response slot; >=3 cycles/transfer,
// cmd_ready low while busy or slot full. APB5_REQ_WAKEUP_EN selects the registered pwakeup hold logic.
module apb5_requester
  import apb5_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned USER_REQ_WIDTH  = 4,
  parameter int unsigned USER_DATA_WIDTH = 4,
  parameter int unsigned USER_RESP_WIDTH = 4,
  parameter int unsigned WAKEUP_HOLD     = 2
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [2:0]                 cmd_prot,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]    cmd_strb,
  input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
  input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_slverr,
  output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
  output logic [USER_RESP_WIDTH-1:0] rsp_buser,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [2:0]                 pprot,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_WIDTH-1:0]      pwdata,
  output logic [DATA_WIDTH/8-1:0]    pstrb,
  output logic                       pwakeup,
  output logic [USER_REQ_WIDTH-1:0]  pauser,
  output logic [USER_DATA_WIDTH-1:0] pwuser,
  input  logic                       pready,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pslverr,
  input  logic [USER_DATA_WIDTH-1:0] pruser,
  input  logic [USER_RESP_WIDTH-1:0] pbuser
);

  localparam int unsigned SW = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
    $error("apb5_requester: DATA_WIDTH must be 8, 16 or 32");
  end
  if (WAKEUP_HOLD < 1) begin : g_bad_hold
    $error("apb5_requester: WAKEUP_HOLD must be at least 1");
  end

  apb_state_e state_q, state_d;

  logic                       accept;
  logic                       xfer_done;

  logic [ADDR_WIDTH-1:0]      paddr_q;
  logic [2:0]                 pprot_q;
  logic                       pwrite_q;
  logic [DATA_WIDTH-1:0]      pwdata_q;
  logic [SW-1:0]              pstrb_q;
  logic [USER_REQ_WIDTH-1:0]  pauser_q;
  logic [USER_DATA_WIDTH-1:0] pwuser_q;

  logic                       rsp_valid_q;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q;
  logic                       rsp_slverr_q;
  logic [USER_DATA_WIDTH-1:0] rsp_ruser_q;
  logic [USER_RESP_WIDTH-1:0] rsp_buser_q;

  // A free slot, or one being drained this cycle, lets a new command in.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign xfer_done = (state_q == ACCESS) && pready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured once on accept and held through SETUP/ACCESS and beyond.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pauser_q <= '0;
      pwuser_q <= '0;
    end else if (accept) begin
      paddr_q  <= cmd_addr;
      pprot_q  <= cmd_prot;
      pwrite_q <= cmd_write;
      pwdata_q <= cmd_write ? cmd_wdata : '0;
      pstrb_q  <= cmd_write ? cmd_strb  : '0;
      pauser_q <= cmd_auser;
      pwuser_q <= cmd_write ? cmd_wuser : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      rsp_ruser_q  <= '0;
      rsp_buser_q  <= '0;
    end else if (xfer_done) begin
      rsp_valid_q  <= 1'b1;
      rsp_rdata_q  <= pwrite_q ? '0 : prdata;
      rsp_slverr_q <= pslverr;
      rsp_ruser_q  <= pwrite_q ? '0 : pruser;
      rsp_buser_q  <= pbuser;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

`ifdef APB5_REQ_WAKEUP_EN
  apb5_wakeup_ctrl #(
    .WAKEUP_HOLD (WAKEUP_HOLD)
  ) u_wakeup (
    .pclk        (pclk),
    .preset      (preset),
    .idle_i      (state_q == IDLE),
    .cmd_valid_i (cmd_valid),
    .pwakeup_o   (pwakeup)
  );
`else
  logic pwakeup_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      pwakeup_q <= 1'b0;
    end else begin
      pwakeup_q <= 1'b1;
    end
  end

  assign pwakeup = pwakeup_q;
`endif

  assign psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign penable    = (state_q == ACCESS);
  assign paddr      = paddr_q;
  assign pprot      = pprot_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;
  assign pauser     = pauser_q;
  assign pwuser     = pwuser_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
  assign rsp_ruser  = rsp_ruser_q;
  assign rsp_buser  = rsp_buser_q;

endmodule
